// File: rtl/led_bank.sv
// led_bank: registered LED bank with per-bit load enables and a stretched RAM-activity indicator
module led_bank #(
  parameter int N_LEDS  = 8,
  parameter int ACT_BIT = 7,
  parameter int STRETCH = 5000000,
  parameter int CNT_W   = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_LEDS-1:0] led_input,
  input  logic [N_LEDS-1:0] leds_sel,
  input  logic              ram_led,
  output logic [N_LEDS-1:0] leds
);
  logic [N_LEDS-1:0] led_reg;
  logic [CNT_W-1:0]  act_cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      led_reg <= '0;
      act_cnt <= '0;
    end else begin
      led_reg <= (leds_sel & led_input) | (~leds_sel & led_reg);
      act_cnt <= ram_led ? CNT_W'(STRETCH) : (act_cnt != '0) ? act_cnt - 1'b1 : act_cnt;
    end
  // activity only ever ORs into the visible LED; led_reg keeps the software value
  always_comb begin
    leds = led_reg;
    leds[ACT_BIT] = led_reg[ACT_BIT] | (act_cnt != '0);
  end
endmodule

// File: tb/tb_led_bank.sv
// tb_led_bank: table-driven checks of led_bank with STRETCH=4, CNT_W=3
module tb_led_bank;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] led_input, leds_sel, leds;
  logic       ram_led;
  int         errors = 0, checks = 0;

  led_bank #(.N_LEDS(8), .ACT_BIT(7), .STRETCH(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .led_input(led_input), .leds_sel(leds_sel),
    .ram_led(ram_led), .leds(leds)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sel;
    logic [7:0] inp;
    logic       ram;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[29];

  task automatic chk(input string name, input logic [7:0] exp);
    checks++;
    if (leds !== exp) begin
      errors++;
      $display("FAIL %s: leds=%h expected=%h at %0t", name, leds, exp, $time);
    end
  endtask

  task automatic step(input logic [7:0] sel, input logic [7:0] inp, input logic ram);
    leds_sel = sel;
    led_input = inp;
    ram_led = ram;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs = '{
      '{8'hFF, 8'h00, 1'b0, 8'h00},
      '{8'hFF, 8'hA5, 1'b0, 8'hA5},
      '{8'hFF, 8'h3C, 1'b0, 8'h3C},
      '{8'h0F, 8'hFF, 1'b0, 8'h3F},
      '{8'h00, 8'h00, 1'b0, 8'h3F},
      '{8'hFF, 8'h00, 1'b0, 8'h00},
      '{8'hFF, 8'h00, 1'b1, 8'h80},
      '{8'hFF, 8'h00, 1'b0, 8'h80},
      '{8'hFF, 8'h00, 1'b0, 8'h80},
      '{8'hFF, 8'h00, 1'b0, 8'h80},
      '{8'hFF, 8'h00, 1'b0, 8'h00},
      '{8'hFF, 8'h00, 1'b1, 8'h80},
      '{8'hFF, 8'h00, 1'b0, 8'h80},
      '{8'hFF, 8'h00, 1'b1, 8'h80},
      '{8'hFF, 8'h00, 1'b0, 8'h80},
      '{8'hFF, 8'h00, 1'b0, 8'h80},
      '{8'hFF, 8'h00, 1'b0, 8'h80},
      '{8'hFF, 8'h00, 1'b0, 8'h00},
      '{8'hFF, 8'h81, 1'b1, 8'h81},
      '{8'hFF, 8'h01, 1'b0, 8'h81},
      '{8'hFF, 8'h01, 1'b0, 8'h81},
      '{8'hFF, 8'h01, 1'b0, 8'h81},
      '{8'hFF, 8'h01, 1'b0, 8'h01},
      '{8'hFF, 8'h01, 1'b1, 8'h81},
      '{8'hFF, 8'h01, 1'b1, 8'h81},
      '{8'hFF, 8'h01, 1'b0, 8'h81},
      '{8'hFF, 8'h01, 1'b0, 8'h81},
      '{8'hFF, 8'h01, 1'b0, 8'h81},
      '{8'hFF, 8'h01, 1'b0, 8'h01}
    };
    reset = 1'b0;
    leds_sel = 8'hFF;
    led_input = 8'hFF;
    ram_led = 1'b1;
    #2;
    chk("reset_async", 8'h00);
    @(posedge clk);
    #1;
    chk("reset_held", 8'h00);
    leds_sel = 8'hFF;
    led_input = 8'h00;
    ram_led = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 29; i++) begin
      step(vecs[i].sel, vecs[i].inp, vecs[i].ram);
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end
    step(8'hFF, 8'hFF, 1'b1);
    chk("pre_reset_stretch", 8'hFF);
    step(8'h00, 8'h00, 1'b0);
    chk("mid_stretch", 8'hFF);
    #2;
    reset = 1'b0;
    #1;
    chk("reset_mid_stretch", 8'h00);
    #1;
    reset = 1'b1;
    step(8'h00, 8'h00, 1'b0);
    chk("no_residual_1", 8'h00);
    step(8'h00, 8'h00, 1'b0);
    chk("no_residual_2", 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
